// File: rtl/timestamp_inserter.sv
// timestamp_inserter: egress stage behind the rate limiter.
// Writes a free-running cycle counter into the IPv4 header field of each
// SOP flit. The field is at [512-TIMESTAMP_OFFSET-TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH].
// The stage is a registered 512-bit pass-through. A 2-entry skid buffer sits
// between input and output, so ready is a register and throughput stays full.
// It also counts stamped packets and SOP/EOP framing errors.
// Optional build macro TS_BYTE_SWAP_EN stamps the value in network byte order.
// That option needs TIMESTAMP_WIDTH to be a multiple of 8.
module timestamp_inserter #(
  parameter int TIMESTAMP_WIDTH  = 32,
  parameter int TIMESTAMP_OFFSET = 144
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] in_pkt_data,
  input  logic         in_pkt_valid,
  output logic         in_pkt_ready,
  input  logic         in_pkt_sop,
  input  logic         in_pkt_eop,
  input  logic [5:0]   in_pkt_empty,
  output logic [511:0] out_pkt_data,
  output logic         out_pkt_valid,
  input  logic         out_pkt_ready,
  output logic         out_pkt_sop,
  output logic         out_pkt_eop,
  output logic [5:0]   out_pkt_empty,
  input  logic         conf_ts_enable,
  input  logic         conf_ts_valid,
  output logic         conf_ts_ready,
  output logic [31:0]  stat_pkt_cnt,
  output logic [15:0]  stat_err_cnt
);

  localparam int FIELD_LSB = 512 - TIMESTAMP_OFFSET - TIMESTAMP_WIDTH;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                     state_q, state_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_cnt;
  logic [TIMESTAMP_WIDTH-1:0] ts_field;
  logic                       ts_enable;
  logic                       pend_valid;
  logic                       pend_enable;
  logic                       in_ready_q;
  logic [1:0][511:0]          buf_data;
  logic [1:0]                 buf_sop;
  logic [1:0]                 buf_eop;
  logic [1:0][5:0]            buf_empty;
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 count;
  logic [1:0]                 count_next;
  logic                       in_xfer;
  logic                       out_xfer;
  logic                       frame_err;
  logic                       do_stamp;
  logic                       cfg_apply;
  logic [511:0]               stamp_data;

  assign in_pkt_ready  = in_ready_q;
  assign conf_ts_ready = 1'b1;
  assign out_pkt_valid = (count != 2'd0);
  assign out_pkt_data  = buf_data[rd_ptr];
  assign out_pkt_sop   = buf_sop[rd_ptr];
  assign out_pkt_eop   = buf_eop[rd_ptr];
  assign out_pkt_empty = buf_empty[rd_ptr];

  assign in_xfer   = in_pkt_valid & in_ready_q;
  assign out_xfer  = out_pkt_valid & out_pkt_ready;
  assign do_stamp  = in_xfer & in_pkt_sop & ts_enable;
  // The new enable takes effect only between packets. It waits while an SOP
  // is being accepted, so that SOP is stamped with the old enable.
  assign cfg_apply = pend_valid & (state_q == IDLE) & ~(in_xfer & in_pkt_sop);

`ifdef TS_BYTE_SWAP_EN
  // Reverse the counter byte by byte to get network byte order.
  always_comb begin
    ts_field = '0;
    for (int b = 0; b < TIMESTAMP_WIDTH / 8; b++) begin
      ts_field[8*b +: 8] = ts_cnt[TIMESTAMP_WIDTH-8-8*b +: 8];
    end
  end
`else
  assign ts_field = ts_cnt;
`endif

  // Overwrite the timestamp field of an SOP flit while stamping is enabled.
  always_comb begin
    stamp_data = in_pkt_data;
    if (in_pkt_sop && ts_enable) begin
      stamp_data[FIELD_LSB +: TIMESTAMP_WIDTH] = ts_field;
    end
  end

  // Compute the buffer occupancy after this cycle's input and output transfers.
  always_comb begin
    count_next = count;
    case ({in_xfer, out_xfer})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Track packet framing on accepted flits and flag bad SOP/EOP sequences.
  always_comb begin
    state_d   = state_q;
    frame_err = 1'b0;
    if (in_xfer) begin
      if (in_pkt_sop) begin
        frame_err = (state_q == IN_PKT);
        state_d   = in_pkt_eop ? IDLE : IN_PKT;
      end else if (state_q == IDLE) begin
        frame_err = 1'b1;
      end else if (in_pkt_eop) begin
        state_d = IDLE;
      end
    end
  end

  // Hold the framing state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Free-running timestamp counter. It wraps and ignores stalls and enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  // Capture config writes into a pending register and move them into the
  // live enable at a packet boundary. A fresh write always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid  <= 1'b0;
      pend_enable <= 1'b0;
      ts_enable   <= 1'b0;
    end else begin
      if (cfg_apply) begin
        ts_enable  <= pend_enable;
        pend_valid <= 1'b0;
      end
      if (conf_ts_valid) begin
        pend_valid  <= 1'b1;
        pend_enable <= conf_ts_enable;
      end
    end
  end

  // Skid buffer. Input writes at wr_ptr, output reads at rd_ptr, and ready is
  // registered from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data   <= '0;
      buf_sop    <= '0;
      buf_eop    <= '0;
      buf_empty  <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      if (in_xfer) begin
        buf_data[wr_ptr]  <= stamp_data;
        buf_sop[wr_ptr]   <= in_pkt_sop;
        buf_eop[wr_ptr]   <= in_pkt_eop;
        buf_empty[wr_ptr] <= in_pkt_empty;
        wr_ptr            <= ~wr_ptr;
      end
      if (out_xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      count      <= count_next;
      in_ready_q <= (count_next != 2'd2);
    end
  end

  // Count stamped packets (wrapping) and framing errors (saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_cnt <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (do_stamp) begin
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      end
      if (frame_err && (stat_err_cnt != 16'hFFFF)) begin
        stat_err_cnt <= stat_err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_timestamp_inserter.sv
// tb_timestamp_inserter: table-driven directed bench for timestamp_inserter.
// A second instance uses an 8-bit counter so the wrap case is reachable.
module tb_timestamp_inserter;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [5:0]  empty;
    logic [31:0] tag;
    logic        exp_stamp;
    logic        conf_wr;
    logic        conf_en;
  } vec_t;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;

`ifdef TS_BYTE_SWAP_EN
  localparam logic [31:0] STAMP_0X10 = 32'h1000_0000;
`else
  localparam logic [31:0] STAMP_0X10 = 32'h0000_0010;
`endif

  logic         clk;
  logic         rst_n;
  logic [511:0] in_pkt_data;
  logic         in_pkt_valid;
  logic         in_pkt_ready;
  logic         in_pkt_sop;
  logic         in_pkt_eop;
  logic [5:0]   in_pkt_empty;
  logic [511:0] out_pkt_data;
  logic         out_pkt_valid;
  logic         out_pkt_ready;
  logic         out_pkt_sop;
  logic         out_pkt_eop;
  logic [5:0]   out_pkt_empty;
  logic         conf_ts_enable;
  logic         conf_ts_valid;
  logic         conf_ts_ready;
  logic [31:0]  stat_pkt_cnt;
  logic [15:0]  stat_err_cnt;

  logic [511:0] w_in_data;
  logic         w_in_valid;
  logic         w_in_ready;
  logic         w_in_sop;
  logic         w_in_eop;
  logic [511:0] w_out_data;
  logic         w_out_valid;
  logic         w_out_sop;
  logic         w_out_eop;
  logic [5:0]   w_out_empty;
  logic         w_conf_en;
  logic         w_conf_valid;
  logic         w_conf_ready;
  logic [31:0]  w_pkt_cnt;
  logic [15:0]  w_err_cnt;

  int           total;
  int           bad;
  logic [31:0]  tb_ts;
  flit_t        expq[$];
  logic [7:0]   stall_pat;
  int           stall_len;
  int           occ;
  int           after_rst;
  logic         saw_full;
  logic         prev_stall;
  flit_t        prev_flit;
  vec_t         vt[12];

  timestamp_inserter dut (
    .clk(clk), .rst_n(rst_n),
    .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
    .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop), .in_pkt_empty(in_pkt_empty),
    .out_pkt_data(out_pkt_data), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
    .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop), .out_pkt_empty(out_pkt_empty),
    .conf_ts_enable(conf_ts_enable), .conf_ts_valid(conf_ts_valid), .conf_ts_ready(conf_ts_ready),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_err_cnt(stat_err_cnt)
  );

  timestamp_inserter #(.TIMESTAMP_WIDTH(8), .TIMESTAMP_OFFSET(144)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_pkt_data(w_in_data), .in_pkt_valid(w_in_valid), .in_pkt_ready(w_in_ready),
    .in_pkt_sop(w_in_sop), .in_pkt_eop(w_in_eop), .in_pkt_empty(6'd0),
    .out_pkt_data(w_out_data), .out_pkt_valid(w_out_valid), .out_pkt_ready(1'b1),
    .out_pkt_sop(w_out_sop), .out_pkt_eop(w_out_eop), .out_pkt_empty(w_out_empty),
    .conf_ts_enable(w_conf_en), .conf_ts_valid(w_conf_valid), .conf_ts_ready(w_conf_ready),
    .stat_pkt_cnt(w_pkt_cnt), .stat_err_cnt(w_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle counter: value of the timestamp in the current cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= 32'd0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  function automatic logic [31:0] netOrder(input logic [31:0] v);
`ifdef TS_BYTE_SWAP_EN
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge. Holds the flit until it is accepted, records the
  // expected output, and returns at the falling edge after acceptance.
  task automatic applyStimulus(input vec_t v);
    logic [511:0] d;
    flit_t        e;
    int           guard;
    d              = {16{v.tag}};
    in_pkt_data    = d;
    in_pkt_sop     = v.sop;
    in_pkt_eop     = v.eop;
    in_pkt_empty   = v.empty;
    in_pkt_valid   = 1'b1;
    conf_ts_valid  = v.conf_wr;
    conf_ts_enable = v.conf_en;
    guard          = 0;
    while (!in_pkt_ready && guard < 50) begin
      @(negedge clk);
      conf_ts_valid = 1'b0;
      guard++;
    end
    if (!in_pkt_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got ready=0 expected ready=1 tag=%0h", v.tag);
    end else begin
      e.data  = d;
      if (v.exp_stamp) e.data[336 +: 32] = netOrder(tb_ts);
      e.sop   = v.sop;
      e.eop   = v.eop;
      e.empty = v.empty;
      expq.push_back(e);
    end
    @(negedge clk);
    in_pkt_valid  = 1'b0;
    conf_ts_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Downstream ready: follows a stall pattern when one is loaded, otherwise 1.
  always @(negedge clk) begin
    if (stall_len > 0) begin
      out_pkt_ready = stall_pat[0];
      stall_pat     = stall_pat >> 1;
      stall_len     = stall_len - 1;
    end else begin
      out_pkt_ready = 1'b1;
    end
  end

  // Output monitor and checks:
  // - scoreboard comparison of each output transfer,
  // - data stays stable while stalled,
  // - ready is low exactly when both buffer entries are occupied.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      occ        = 0;
      after_rst  = 0;
      prev_stall = 1'b0;
    end else begin
      if (after_rst > 0) checkOutput("in_ready_vs_occ", in_pkt_ready, (occ != 2));
      after_rst++;
      if (occ == 2) saw_full = 1'b1;
      if (prev_stall) begin
        checkOutput("stall_valid", out_pkt_valid, 1'b1);
        checkOutput("stall_data", out_pkt_data, prev_flit.data);
        checkOutput("stall_ctrl", {out_pkt_sop, out_pkt_eop, out_pkt_empty},
                    {prev_flit.sop, prev_flit.eop, prev_flit.empty});
      end
      if (out_pkt_valid && out_pkt_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_flit: got data %0h expected none", out_pkt_data);
        end else begin
          flit_t e;
          e = expq.pop_front();
          checkOutput("out_data", out_pkt_data, e.data);
          checkOutput("out_ctrl", {out_pkt_sop, out_pkt_eop, out_pkt_empty}, {e.sop, e.eop, e.empty});
        end
      end
      prev_stall      = out_pkt_valid && !out_pkt_ready;
      prev_flit.data  = out_pkt_data;
      prev_flit.sop   = out_pkt_sop;
      prev_flit.eop   = out_pkt_eop;
      prev_flit.empty = out_pkt_empty;
      occ = occ + ((in_pkt_valid && in_pkt_ready) ? 1 : 0) - ((out_pkt_valid && out_pkt_ready) ? 1 : 0);
    end
  end

  initial begin
    vec_t         v1;
    logic [511:0] wexp;
    int           g;

    total = 0; bad = 0; stall_len = 0; stall_pat = '0; saw_full = 1'b0;
    occ = 0; after_rst = 0; prev_stall = 1'b0; prev_flit = '0;
    rst_n = 1'b0;
    in_pkt_data = '0; in_pkt_valid = 1'b0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0; in_pkt_empty = '0;
    conf_ts_enable = 1'b0; conf_ts_valid = 1'b0;
    w_in_data = '0; w_in_valid = 1'b0; w_in_sop = 1'b0; w_in_eop = 1'b0;
    w_conf_en = 1'b0; w_conf_valid = 1'b0;

    // Vectors: {sop, eop, empty, tag, exp_stamp, conf_wr, conf_en}
    vt[0]  = '{1'b1, 1'b0, 6'd0,  32'hA0A0_0000, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 6'd0,  32'hA0A0_0001, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 6'd0,  32'hA0A0_0002, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 6'd5,  32'hA0A0_0003, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 6'd0,  32'hB0B0_0000, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 6'd0,  32'hB0B0_0001, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 6'd12, 32'hB0B0_0002, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 6'd0,  32'hC0C0_0000, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 6'd7,  32'hC0C0_0001, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 6'd0,  32'hD0D0_0000, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 6'd0,  32'hD0D0_0001, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 6'd3,  32'hD0D0_0002, 1'b1, 1'b0, 1'b0};

    // Reset state
    #2;
    checkOutput("rst_out_valid", out_pkt_valid, 1'b0);
    checkOutput("rst_in_ready", in_pkt_ready, 1'b0);
    checkOutput("rst_pkt_cnt", stat_pkt_cnt, 32'd0);
    checkOutput("rst_err_cnt", stat_err_cnt, 16'd0);
    checkOutput("conf_ready", conf_ts_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    conf_ts_valid = 1'b1; conf_ts_enable = 1'b1;
    w_conf_valid = 1'b1; w_conf_en = 1'b1;
    #1 checkOutput("ready_low_before_edge", in_pkt_ready, 1'b0);
    @(negedge clk);
    conf_ts_valid = 1'b0; w_conf_valid = 1'b0;
    #1 checkOutput("ready_after_reset", in_pkt_ready, 1'b1);

    // Single-flit packet accepted at ts 0x10
    @(negedge clk);
    g = 0;
    while (tb_ts != 32'h10 && g < 100) begin @(negedge clk); g++; end
    checkOutput("reach_ts_0x10", tb_ts, 32'h10);
    v1 = '{1'b1, 1'b1, 6'd9, 32'h1111_2222, 1'b1, 1'b0, 1'b0};
    applyStimulus(v1);
    #1;
    checkOutput("single_out_valid", out_pkt_valid, 1'b1);
    checkOutput("single_field", out_pkt_data[336 +: 32], STAMP_0X10);
    checkOutput("single_pkt_cnt", stat_pkt_cnt, 32'd1);

    // 4-flit packet with a toggling downstream ready (LSB first: 0,0,1,0,1,0,1,1)
    #2;
    stall_pat = 8'hD4; stall_len = 8;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vt[i]);
      if (vt[i].eop) idleCycles(1);
    end
    idleCycles(8);
    checkOutput("stall_saw_full", saw_full, 1'b1);
    checkOutput("pkt_cnt_after_4flit", stat_pkt_cnt, 32'd2);

    // Disable written mid-packet, then an unstamped packet
    for (int i = 4; i < 9; i++) begin
      applyStimulus(vt[i]);
      if (vt[i].eop) idleCycles(1);
    end
    idleCycles(6);
    checkOutput("pkt_cnt_after_disable", stat_pkt_cnt, 32'd3);

    // Re-enable, then framing errors
    conf_ts_valid = 1'b1; conf_ts_enable = 1'b1;
    @(negedge clk);
    conf_ts_valid = 1'b0;
    idleCycles(3);
    for (int i = 9; i < 12; i++) begin
      applyStimulus(vt[i]);
      if (vt[i].eop) idleCycles(1);
    end
    idleCycles(6);
    checkOutput("err_cnt_framing", stat_err_cnt, 16'd2);
    checkOutput("pkt_cnt_framing", stat_pkt_cnt, 32'd5);

    // Counter wrap on the 8-bit instance: stamps at 0xFF and then at 0x02
    g = 0;
    while (tb_ts[7:0] != 8'hFF && g < 300) begin @(negedge clk); g++; end
    checkOutput("reach_ts_0xff", tb_ts[7:0], 8'hFF);
    checkOutput("w_ready", w_in_ready, 1'b1);
    w_in_valid = 1'b1; w_in_sop = 1'b1; w_in_eop = 1'b1; w_in_data = '0;
    @(negedge clk);
    w_in_valid = 1'b0;
    wexp = '0;
    wexp[360 +: 8] = 8'hFF;
    #1 checkOutput("wrap_ff_valid", w_out_valid, 1'b1);
    checkOutput("wrap_ff_data", w_out_data, wexp);
    @(negedge clk);
    @(negedge clk);
    w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    wexp[360 +: 8] = 8'h02;
    #1 checkOutput("wrap_02_valid", w_out_valid, 1'b1);
    checkOutput("wrap_02_data", w_out_data, wexp);
    checkOutput("wrap_pkt_cnt", w_pkt_cnt, 32'd2);

    // Reset while two flits sit in the buffer
    #2;
    stall_pat = 8'h00; stall_len = 10;
    @(negedge clk);
    v1 = '{1'b1, 1'b0, 6'd0, 32'hE0E0_0000, 1'b1, 1'b0, 1'b0};
    applyStimulus(v1);
    v1 = '{1'b0, 1'b0, 6'd0, 32'hE0E0_0001, 1'b0, 1'b0, 1'b0};
    applyStimulus(v1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_pkt_valid, 1'b0);
    checkOutput("midrst_in_ready", in_pkt_ready, 1'b0);
    checkOutput("midrst_pkt_cnt", stat_pkt_cnt, 32'd0);
    expq.delete();
    stall_len = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);
    v1 = '{1'b1, 1'b1, 6'd4, 32'hF0F0_0000, 1'b0, 1'b0, 1'b0};
    applyStimulus(v1);
    idleCycles(4);
    checkOutput("post_rst_err_cnt", stat_err_cnt, 16'd0);
    checkOutput("post_rst_pkt_cnt", stat_pkt_cnt, 32'd0);
    checkOutput("exp_queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
